// File: rtl/dvs_ravens_pkg.sv
// ============================================================================
// Module   : dvs_ravens_pkg
// Purpose  : Shared timestamp widths, event record type and release FSM states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dvs_ravens_pkg;

   localparam int TIMESTAMP_US_BITS = 16;
   localparam int EVT_PAYLOAD_BITS  = 16;

   typedef struct packed {
      logic [TIMESTAMP_US_BITS-1:0] ts;
      logic [EVT_PAYLOAD_BITS-1:0]  payload;
   } event_ts_t;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      WAIT    = 2'd1,
      PRESENT = 2'd2
   } release_state_t;

   // Modular due test: the timestamp is due when it lies at most half-range in the past.
   function automatic logic ts_is_due(input logic [TIMESTAMP_US_BITS-1:0] now,
                                      input logic [TIMESTAMP_US_BITS-1:0] ts);
      logic [TIMESTAMP_US_BITS-1:0] diff;
      diff = now - ts;
      return ~diff[TIMESTAMP_US_BITS-1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/event_release_scheduler_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO, registered storage, head word always presented.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int                c_aw    = $clog2(DEPTH);
   localparam logic [c_aw:0]     c_depth = (c_aw + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
   logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
   logic [c_aw:0]    count_q, count_d;
   logic             w_wr, w_rd;

   assign w_wr = wr_en && (count_q < c_depth);
   assign w_rd = rd_en && (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd) rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_wr && !w_rd)      count_d = count_q + 1'b1;
      else if (!w_wr && w_rd) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers define which words are valid.
   always_ff @(posedge clk) begin
      if (w_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];
   assign count   = count_q;

endmodule

`default_nettype wire

// File: rtl/event_release_scheduler.sv
// ============================================================================
// Module   : event_release_scheduler
// Purpose  : Buffers timestamped events and releases each once time_us reaches
//            its timestamp. Optional lateness stats: EVENT_RELEASE_LATE_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_release_scheduler
   import dvs_ravens_pkg::*;
#(
   parameter int FIFO_DEPTH        = 8,
`ifdef EVENT_RELEASE_LATE_COUNT_EN
   parameter int LATE_THRESHOLD_US = 4,
`endif
   parameter int PAYLOAD_BITS      = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [TIMESTAMP_US_BITS-1:0]   time_us,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [TIMESTAMP_US_BITS-1:0]   in_ts_us,
   input  logic [PAYLOAD_BITS-1:0]        in_payload,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [PAYLOAD_BITS-1:0]        out_payload,
   output logic [TIMESTAMP_US_BITS-1:0]   out_ts_us,
`ifdef EVENT_RELEASE_LATE_COUNT_EN
   output logic [15:0]                    late_count,
   output logic                           late_flag,
`endif
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int                  c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam logic [c_cnt_w-1:0]  c_depth = c_cnt_w'(FIFO_DEPTH);
   localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

   release_state_t                 state_q, state_d;
   logic [PAYLOAD_BITS-1:0]        out_payload_q, out_payload_d;
   logic [TIMESTAMP_US_BITS-1:0]   out_ts_q, out_ts_d;

   event_ts_t                      w_push_data;
   event_ts_t                      w_head;
   logic [c_cnt_w-1:0]             w_count;
   logic                           w_push, w_pop;

   assign in_ready    = (w_count < c_depth);
   assign w_push      = in_valid && in_ready;
   assign w_pop       = (state_q == PRESENT) && out_ready;
   assign w_push_data = '{ts: in_ts_us, payload: in_payload};

   sync_fifo #(
      .WIDTH ($bits(event_ts_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_push),
      .wr_data (w_push_data),
      .rd_en   (w_pop),
      .rd_data (w_head),
      .count   (w_count)
   );

   // The presented event stays at the FIFO head until its handshake pops it.
   always_comb begin
      state_d       = state_q;
      out_payload_d = out_payload_q;
      out_ts_d      = out_ts_q;
      unique case (state_q)
         EMPTY: begin
            if (w_count != '0) state_d = WAIT;
         end
         WAIT: begin
            if (ts_is_due(time_us, w_head.ts)) begin
               out_payload_d = w_head.payload;
               out_ts_d      = w_head.ts;
               state_d       = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) state_d = ((w_count > c_one) || w_push) ? WAIT : EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= EMPTY;
         out_payload_q <= '0;
         out_ts_q      <= '0;
      end else begin
         state_q       <= state_d;
         out_payload_q <= out_payload_d;
         out_ts_q      <= out_ts_d;
      end
   end

   assign out_valid   = (state_q == PRESENT);
   assign out_payload = out_payload_q;
   assign out_ts_us   = out_ts_q;
   assign fifo_count  = w_count;

`ifdef EVENT_RELEASE_LATE_COUNT_EN
   localparam logic [TIMESTAMP_US_BITS-1:0] c_late_thr = TIMESTAMP_US_BITS'(LATE_THRESHOLD_US);

   logic [15:0]                    late_count_q, late_count_d;
   logic                           late_flag_q, late_flag_d;
   logic [TIMESTAMP_US_BITS-1:0]   w_late_diff;
   logic                           w_late;

   assign w_late_diff = time_us - out_ts_q;
   assign w_late      = w_pop && (w_late_diff > c_late_thr);

   always_comb begin
      late_count_d = late_count_q;
      late_flag_d  = w_late;
      if (w_late && (late_count_q != 16'hFFFF)) late_count_d = late_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         late_count_q <= '0;
         late_flag_q  <= 1'b0;
      end else begin
         late_count_q <= late_count_d;
         late_flag_q  <= late_flag_d;
      end
   end

   assign late_count = late_count_q;
   assign late_flag  = late_flag_q;
`endif

endmodule

`default_nettype wire
